router_pkt_tx: RTL

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers up to 63 payload bytes and sends them to a router as one packet.
// The packet is a header {len, dest}, the payload, then a parity byte.
// Optional feature macro: PKT_TX_PARITY_INJECT_EN adds the corrupt_parity input, which
// flips bit 0 of the transmitted parity byte for the packet it is launched with.
module router_pkt_tx (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic        start,
   input  logic [1:0]  dest_addr,
   input  logic        busy,
   input  logic        error,
`ifdef PKT_TX_PARITY_INJECT_EN
   input  logic        corrupt_parity,
`endif
   output logic        pkt_valid,
   output logic [7:0]  pkt_data,
   output logic        buf_full,
   output logic        tx_idle,
   output logic        tx_done,
   output logic        req_err,
   output logic        err_seen,
   output logic [15:0] pkt_count
);

   typedef enum logic [2:0] {StIdle, StHeader, StPayload, StParity, StErrWait, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [5:0]  rd_ptr_q, rd_ptr_d;
   logic [5:0]  len_q, len_d;
   logic [1:0]  addr_q, addr_d;
   logic [7:0]  parity_q, parity_d;
   logic        ew_q, ew_d;
   logic        err_seen_q, err_seen_d;
   logic        req_err_q, req_err_d;
   logic [15:0] pkt_count_q, pkt_count_d;
   logic        inj_q, inj_d;
   logic        mem_we;
   logic [7:0]  mem [64];

   // A byte is taken by the router on any edge where it is not stalling.
   logic accept;
   assign accept = ~busy;

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      addr_d      = addr_q;
      parity_d    = parity_q;
      ew_d        = ew_q;
      err_seen_d  = err_seen_q;
      req_err_d   = 1'b0;
      pkt_count_d = pkt_count_q;
      inj_d       = inj_q;
      mem_we      = 1'b0;
      case (state_q)
         StIdle: begin
            if (wr_en && count_q != 6'd63) begin
               mem_we  = 1'b1;
               count_d = count_q + 6'd1;
            end
            if (start) begin
               if (dest_addr == 2'd3 || count_q == 6'd0) begin
                  req_err_d = 1'b1;
               end else begin
                  state_d    = StHeader;
                  len_d      = count_q;
                  addr_d     = dest_addr;
                  parity_d   = 8'h00;
                  rd_ptr_d   = 6'd0;
                  err_seen_d = 1'b0;
`ifdef PKT_TX_PARITY_INJECT_EN
                  inj_d      = corrupt_parity;
`else
                  inj_d      = 1'b0;
`endif
               end
            end
         end
         StHeader: begin
            if (accept) begin
               parity_d = parity_q ^ {len_q, addr_q};
               rd_ptr_d = 6'd0;
               state_d  = StPayload;
            end
         end
         StPayload: begin
            if (accept) begin
               parity_d = parity_q ^ mem[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + 6'd1;
               if (rd_ptr_q == len_q - 6'd1) state_d = StParity;
            end
         end
         StParity: begin
            if (accept) begin
               ew_d    = 1'b0;
               state_d = StErrWait;
            end
         end
         StErrWait: begin
            if (error) err_seen_d = 1'b1;
            ew_d = 1'b1;
            if (ew_q) state_d = StDone;
         end
         StDone: begin
            pkt_count_d = pkt_count_q + 16'd1;
            count_d     = 6'd0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= 6'd0;
         rd_ptr_q    <= 6'd0;
         len_q       <= 6'd0;
         addr_q      <= 2'd0;
         parity_q    <= 8'h00;
         ew_q        <= 1'b0;
         err_seen_q  <= 1'b0;
         req_err_q   <= 1'b0;
         pkt_count_q <= 16'd0;
         inj_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         parity_q    <= parity_d;
         ew_q        <= ew_d;
         err_seen_q  <= err_seen_d;
         req_err_q   <= req_err_d;
         pkt_count_q <= pkt_count_d;
         inj_q       <= inj_d;
      end
   end

   // Payload RAM; contents survive reset, only the fill count is cleared.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) mem[count_q] <= wr_data;
   end

   // Router-facing byte and framing, decoded from state; stable while busy holds the state.
   always_comb begin
      pkt_valid = 1'b0;
      pkt_data  = 8'h00;
      case (state_q)
         StHeader: begin
            pkt_valid = 1'b1;
            pkt_data  = {len_q, addr_q};
         end
         StPayload: begin
            pkt_valid = 1'b1;
            pkt_data  = mem[rd_ptr_q];
         end
         StParity: pkt_data = parity_q ^ {7'd0, inj_q};
         default: ;
      endcase
   end

   assign buf_full  = (count_q == 6'd63);
   assign tx_idle   = (state_q == StIdle);
   assign tx_done   = (state_q == StDone);
   assign req_err   = req_err_q;
   assign err_seen  = err_seen_q;
   assign pkt_count = pkt_count_q;

endmodule
